// File: rtl/rca_pkg.sv
// Shared types for the chunked sequential ripple-carry adder.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Width of the chunk counter; a single-chunk build still needs one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from a chain of full adders.
module rca_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] in1,
  input  logic [CHUNK-1:0] in2,
  input  logic             cin,
  output logic [CHUNK-1:0] out,
  output logic             cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign out[gi]    = in1[gi] ^ in2[gi] ^ w_c[gi];
      assign w_c[gi+1] = (in1[gi] & in2[gi]) | (w_c[gi] & (in1[gi] ^ in2[gi]));
    end
  endgenerate

  assign cout = w_c[CHUNK];

endmodule

// File: rtl/rca_seq_chunked.sv
// Multi-cycle add/subtract: one CHUNK-bit adder reused NCHUNK times with a registered carry.
// Optional signed-overflow output is enabled by defining RCA_SEQ_OVF_EN.
module rca_seq_chunked
  import rca_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
`ifdef RCA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("rca_seq_chunked: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_valid;

  logic [CHUNK-1:0] w_a_sel;
  logic [CHUNK-1:0] w_b_sel;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;

  assign w_a_sel = r_a[r_count*CHUNK +: CHUNK];
  assign w_b_sel = r_b[r_count*CHUNK +: CHUNK];

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .in1  (w_a_sel),
    .in2  (w_b_sel),
    .cin  (r_carry),
    .out  (w_sum),
    .cout (w_cout)
  );

`ifdef RCA_SEQ_OVF_EN
  logic r_ovf;
  logic w_c_msb;
  // Carry into the top bit recovered from the sum bit of the final chunk.
  assign w_c_msb = w_a_sel[CHUNK-1] ^ w_b_sel[CHUNK-1] ^ w_sum[CHUNK-1];
  assign ovf     = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_out   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in1;
            r_b     <= sub ? ~in2 : in2;
            r_carry <= cin;
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_out[r_count*CHUNK +: CHUNK] <= w_sum;
          r_carry <= w_cout;
          if (r_count == LAST) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_cout  <= w_cout;
`ifdef RCA_SEQ_OVF_EN
            r_ovf   <= w_c_msb ^ w_cout;
`endif
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ready drops combinationally under reset so nothing is accepted mid-reset.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_valid;
  assign out       = r_out;
  assign cout      = r_cout;

endmodule

// File: doc/rca_seq_chunked.md
Name: rca_seq_chunked

Overview:
- Parametrised, multi-cycle successor to the fixed-width ripple-carry adders.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, reusing one CHUNK-bit ripple adder and a registered carry between chunks.
- Uses valid/ready handshakes on both input and output, so it can sit in datapaths where area matters more than latency.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 16, bits added per cycle; WIDTH % CHUNK must be 0 (elaboration-time error otherwise).
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/controls valid.
- in_ready  out  1  block can accept operands.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  0 = A+B+cin; 1 = A+~B+cin (cin=1 gives A-B).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- cout  out  1  carry-out of MSB.

Interface rule: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset: state=IDLE, out=0, cout=0, out_valid=0, internal carry/count=0. in_ready=0 while rst=1.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in1 and (sub ? ~in2 : in2) into the operand registers, latch carry=cin, count=0, go to RUN.
  - RUN: in_ready=0. Each cycle, chunk[count] of the result = A[count] + B[count] + carry, with carry updated to the chunk carry-out. When count==NCHUNK-1, go to HOLD with out_valid=1 and cout=final carry; otherwise count+1.
  - HOLD: out_valid=1; out and cout held stable. in_ready=0; in_valid is ignored. On out_ready, go to IDLE with out_valid=0 in the next cycle.
- Latency:
  - Accept at edge t; out_valid rises after edge t+NCHUNK.
  - The earliest next accept is the cycle after the result handshake; there is no same-cycle result-out/operand-in.
- Width: arithmetic is modulo 2^WIDTH and cout is the true carry out of bit WIDTH-1. For sub=1, cout=1 means no borrow.
- out retains the last result in IDLE. It changes only when chunks are written during RUN; chunks not yet computed hold their previous value, and out is meaningful only when out_valid=1.
- CHUNK==WIDTH: NCHUNK=1 and latency is 1 cycle.
- rst mid-RUN or mid-HOLD aborts: no result is emitted, and all outputs return to their reset values.
- Operand inputs changing after acceptance have no effect.

Optional Feature:
- Macro RCA_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit) = signed overflow = carry into bit WIDTH-1 XOR cout. It is registered with cout, reset to 0, and held in HOLD.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package rca_pkg: state enum (IDLE, RUN, HOLD), and a function computing the count width $clog2(NCHUNK) (minimum 1).
- Sub-module rca_chunk: combinational CHUNK-bit ripple adder (in1, in2, cin -> out, cout) built from full adders. It is instantiated once and indexed by count.

Test Plan (WIDTH=64, CHUNK=16 unless stated):
1. in1=0xFFFF_FFFF_FFFF_FFFF, in2=1, cin=0, sub=0 -> out=0, cout=1, out_valid exactly 4 cycles after accept.
2. in1=5, in2=7, sub=1, cin=1 -> out=0xFFFF_FFFF_FFFF_FFFE, cout=0.
3. After a result, hold out_ready=0 for 10 cycles while toggling in_valid/in1 -> out/cout stable, in_ready=0, no new accept; out_ready=1 -> IDLE, next accept is the following cycle.
4. Assert rst for 1 cycle at the 2nd RUN cycle -> out_valid never rises for that operation; out=0, cout=0; in_ready=1 the cycle after rst deasserts.
5. RCA_SEQ_OVF_EN defined: in1=0x7FFF_FFFF_FFFF_FFFF, in2=1 -> out=0x8000_0000_0000_0000, ovf=1, cout=0; in1=in2=0x8000_0000_0000_0000 -> out=0, ovf=1, cout=1.
6. CHUNK=64: in1=3, in2=4, cin=1 -> out=8, latency 1 cycle. CHUNK=8: random vectors checked against the reference sum, latency 8.
